instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
IF stage of the 5-stage MIPS pipeline.
- Holds the PC and a word-addressed instruction memory, loadable through a debug load port.
- Contains the IF/ID pipeline register that drives instruction_decode's i_instruction and i_pc_if.
- Accepts stall from the hazard logic and branch/jump redirect resolved in ID.

Parameters:
SIZE, 32, data/instruction/PC width
IMEM_DEPTH, 256, instruction memory depth in words
SIZE_IMEM_DIR, $clog2(IMEM_DEPTH), word-address width
HALT_WORD, 32'hFFFFFFFF, encoding treated as HALT when the optional feature is compiled in

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
i_stall  input  1  hold PC and IF/ID register (load-use hazard)
i_jump_brch  input  1  redirect request from ID (taken branch/jump)
i_pc_target  input  SIZE  redirect target byte address
i_load_en  input  1  debug program-load mode
i_load_addr  input  SIZE_IMEM_DIR  word address written during load
i_load_data  input  SIZE  instruction word written during load
o_instruction  output  SIZE  IF/ID instruction to decode
o_pc_if  output  SIZE  IF/ID PC+4 of o_instruction (decode's i_pc_if, link value)
o_pc  output  SIZE  current PC (debug)
o_halt  output  1  halt reached (0 when feature absent)

Behaviour:
- Reset (async, any time): PC=0, o_instruction=0 (NOP), o_pc_if=0, o_halt=0. Memory contents are not cleared.
- Fetch: combinational read mem[PC[SIZE_IMEM_DIR+1:2]].
  - PC word index >= IMEM_DEPTH returns 0 (NOP).
  - No wrap of the PC itself.
- Priority each edge: load > redirect > stall > normal.
- Load: while i_load_en=1:
  - mem[i_load_addr] <= i_load_data every cycle.
  - PC forced to 0; o_instruction<=0; o_pc_if<=0; o_halt<=0.
  - First fetch of address 0 occurs the cycle after i_load_en falls.
- Redirect: i_jump_brch=1 and i_stall=0:
  - PC <= {i_pc_target[SIZE-1:2],2'b00}; misaligned targets are silently aligned.
  - IF/ID loads NOP (o_instruction=0, o_pc_if=0) to flush the wrong-path fetch. There is no delay slot.
- Redirect while stalled: i_jump_brch=1 with i_stall=1 is ignored. ID holds its instruction and reasserts the redirect once the stall clears.
- Stall: PC, o_instruction and o_pc_if hold their values.
- Normal:
  - PC <= PC+4, 32-bit modulo arithmetic.
  - o_instruction <= fetched word; o_pc_if <= PC+4.
- Latency: one cycle from PC to IF/ID outputs. Redirect costs exactly one bubble.
- Memory write and fetch of the same word in the same cycle are impossible (PC pinned during load).

Optional Feature:
Macro: HALT_DETECT_EN
- Defined:
  - When the fetched word equals HALT_WORD in a normal (non-stall, non-redirect) cycle, the HALT word is passed into IF/ID and o_halt<=1.
  - While o_halt=1: PC frozen; IF/ID loads NOP each unstalled cycle; redirect and stall are ignored.
  - o_halt is cleared only by rst or i_load_en.
  - A HALT word in the wrong-path slot being flushed does not halt.
- Not defined: HALT_WORD is fetched as an ordinary instruction; o_halt tied 0.

Test Plan:
- Load then run: load mem[0..2]=0x20010005,0x20020007,0x00221820, release i_load_en -> o_instruction shows the three words on consecutive cycles; o_pc_if=4,8,12.
- Stall: assert i_stall 2 cycles while o_instruction=0x20020007 -> it and o_pc_if=8 hold 2 cycles; o_pc does not advance.
- Redirect: i_jump_brch=1, i_pc_target=0x42 at PC=0x10 -> next IF/ID NOP; o_pc=0x40; following cycle fetches mem[16].
- Redirect during stall: i_jump_brch=1 and i_stall=1 -> PC unchanged; retry with i_stall=0 -> redirect taken.
- Async reset mid-run at PC=0x24 -> o_pc, o_instruction, o_pc_if go 0 immediately without a clock edge; mem[0] still holds 0x20010005.
- HALT (HALT_DETECT_EN): mem[3]=0xFFFFFFFF -> o_halt=1 when 0xFFFFFFFF is in IF/ID; o_pc stays 0x10; IF/ID then shows NOP; without the macro, o_halt stays 0 and PC reaches 0x14.

Source files
------------

// File: rtl/instruction_fetch.sv
// IF stage of the 5-stage MIPS pipeline: PC, word-addressed instruction memory with a
// debug load port, and the IF/ID register. Optional HALT detection under HALT_DETECT_EN.
module instruction_fetch #(
    parameter int unsigned SIZE          = 32,
    parameter int unsigned IMEM_DEPTH    = 256,
    parameter int unsigned SIZE_IMEM_DIR = $clog2(IMEM_DEPTH),
    parameter logic [SIZE-1:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_stall,
    input  logic                     i_jump_brch,
    input  logic [SIZE-1:0]          i_pc_target,
    input  logic                     i_load_en,
    input  logic [SIZE_IMEM_DIR-1:0] i_load_addr,
    input  logic [SIZE-1:0]          i_load_data,
    output logic [SIZE-1:0]          o_instruction,
    output logic [SIZE-1:0]          o_pc_if,
    output logic [SIZE-1:0]          o_pc,
    output logic                     o_halt
);

`ifdef HALT_DETECT_EN
    localparam bit HaltEn = 1'b1;
`else
    localparam bit HaltEn = 1'b0;
`endif

    logic [SIZE-1:0] mem [IMEM_DEPTH];
    logic [SIZE-3:0] word_idx;
    logic [SIZE-1:0] fetched;
    logic [SIZE-1:0] pc_next_seq;
    logic            redirect;
    logic            normal;

    // Program memory is written only through the debug load port and never cleared.
    always_ff @(posedge clk) begin
        if (i_load_en) begin
            mem[i_load_addr] <= i_load_data;
        end
    end

    assign word_idx    = o_pc[SIZE-1:2];
    assign pc_next_seq = o_pc + SIZE'(4);
    assign redirect    = i_jump_brch && !i_stall;
    assign normal      = !i_jump_brch && !i_stall;

    // Word indices past the end of memory read as NOP; the PC itself never wraps early.
    always_comb begin
        fetched = '0;
        if (word_idx < (SIZE-2)'(IMEM_DEPTH)) begin
            fetched = mem[word_idx[SIZE_IMEM_DIR-1:0]];
        end
    end

    // PC and IF/ID register; priority is load > halt > redirect > stall > normal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_pc          <= '0;
            o_instruction <= '0;
            o_pc_if       <= '0;
        end else if (i_load_en) begin
            o_pc          <= '0;
            o_instruction <= '0;
            o_pc_if       <= '0;
        end else if (o_halt) begin
            o_instruction <= '0;
            o_pc_if       <= '0;
        end else if (redirect) begin
            o_pc          <= i_pc_target & ~SIZE'(3);
            o_instruction <= '0;
            o_pc_if       <= '0;
        end else if (!i_stall) begin
            o_pc          <= pc_next_seq;
            o_instruction <= fetched;
            o_pc_if       <= pc_next_seq;
        end
    end

    // Halt flag; constant zero unless HALT detection is compiled in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_halt <= 1'b0;
        end else if (i_load_en) begin
            o_halt <= 1'b0;
        end else if (HaltEn && !o_halt && normal && (fetched == HALT_WORD)) begin
            o_halt <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the IF stage.
module tb_instruction_fetch;

    localparam int unsigned SIZE  = 32;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 8;
    localparam logic [31:0] HALTW = 32'hFFFFFFFF;

    logic            clk;
    logic            rst;
    logic            i_stall;
    logic            i_jump_brch;
    logic [31:0]     i_pc_target;
    logic            i_load_en;
    logic [AW-1:0]   i_load_addr;
    logic [31:0]     i_load_data;
    logic [31:0]     o_instruction;
    logic [31:0]     o_pc_if;
    logic [31:0]     o_pc;
    logic            o_halt;

    instruction_fetch dut (
        .clk(clk), .rst(rst), .i_stall(i_stall), .i_jump_brch(i_jump_brch),
        .i_pc_target(i_pc_target), .i_load_en(i_load_en), .i_load_addr(i_load_addr),
        .i_load_data(i_load_data), .o_instruction(o_instruction), .o_pc_if(o_pc_if),
        .o_pc(o_pc), .o_halt(o_halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pc, m_ir, m_pcif;
    logic        m_halt;
    int          n_pass = 0;
    int          n_total = 0;

    task automatic m_reset();
        m_pc = 0; m_ir = 0; m_pcif = 0; m_halt = 1'b0;
    endtask

    task automatic m_step(input logic le, input logic [AW-1:0] la, input logic [31:0] ld,
                          input logic st, input logic jb, input logic [31:0] tg);
        logic [31:0] word;
        word = ((m_pc / 4) < DEPTH) ? m_mem[m_pc / 4] : 32'h0;
        if (le) begin
            m_mem[la] = ld;
            m_reset();
        end else if (m_halt) begin
            m_ir = 0; m_pcif = 0;
        end else if (jb && !st) begin
            m_pc = (tg / 4) * 4; m_ir = 0; m_pcif = 0;
        end else if (!st) begin
            m_ir = word; m_pcif = m_pc + 4; m_pc = m_pc + 4;
`ifdef HALT_DETECT_EN
            if (word == HALTW) m_halt = 1'b1;
`endif
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then advance the model.
    task automatic cyc(input logic le, input logic [AW-1:0] la, input logic [31:0] ld,
                       input logic st, input logic jb, input logic [31:0] tg);
        i_load_en = le; i_load_addr = la; i_load_data = ld;
        i_stall = st; i_jump_brch = jb; i_pc_target = tg;
        @(posedge clk);
        #1;
        m_step(le, la, ld, st, jb, tg);
    endtask

    task automatic test_reset();
        rst = 1'b1; i_load_en = 0; i_load_addr = 0; i_load_data = 0;
        i_stall = 0; i_jump_brch = 0; i_pc_target = 0;
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        n_total++;
        if ({o_instruction, o_pc_if, o_pc, o_halt} !== 97'd0)
            $display("FAIL reset: got ir=%h pcif=%h pc=%h halt=%b want all zero",
                     o_instruction, o_pc_if, o_pc, o_halt);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_load_all();
        logic [31:0] w;
        for (int i = 0; i < int'(DEPTH); i++) begin
            w = $urandom;
            if (w == HALTW) w = 32'h0;
            cyc(1'b1, AW'(i), w, 1'b0, 1'b0, 32'h0);
        end
        n_total++;
        if ({o_instruction, o_pc_if, o_pc, o_halt} !== 97'd0)
            $display("FAIL load_all: got ir=%h pcif=%h pc=%h halt=%b want all zero",
                     o_instruction, o_pc_if, o_pc, o_halt);
        else n_pass++;
    endtask

    task automatic test_load_run();
        logic [31:0] words [3];
        words[0] = 32'h20010005; words[1] = 32'h20020007; words[2] = 32'h00221820;
        for (int i = 0; i < 3; i++) cyc(1'b1, AW'(i), words[i], 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, '0, 32'h0, 1'b0, 1'b0, 32'h0);
            n_total++;
            if (o_instruction !== words[i] || o_pc_if !== 32'(4 * (i + 1)) || o_pc !== 32'(4 * (i + 1)))
                $display("FAIL load_run[%0d]: got ir=%h pcif=%h pc=%h want ir=%h pcif=%h pc=%h",
                         i, o_instruction, o_pc_if, o_pc, words[i], 4 * (i + 1), 4 * (i + 1));
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, '0, 32'h0, 1'b1, 1'b0, 32'h0);
            n_total++;
            if (o_instruction !== 32'h20020007 || o_pc_if !== 32'h8 || o_pc !== 32'h8)
                $display("FAIL stall[%0d]: got ir=%h pcif=%h pc=%h want ir=20020007 pcif=8 pc=8",
                         i, o_instruction, o_pc_if, o_pc);
            else n_pass++;
        end
        cyc(1'b0, '0, 32'h0, 1'b0, 1'b0, 32'h0);
        n_total++;
        if (o_instruction !== 32'h00221820 || o_pc_if !== 32'hC || o_pc !== 32'hC)
            $display("FAIL stall_release: got ir=%h pcif=%h pc=%h want ir=00221820 pcif=c pc=c",
                     o_instruction, o_pc_if, o_pc);
        else n_pass++;
    endtask

    task automatic test_redirect();
        cyc(1'b0, '0, 32'h0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, '0, 32'h0, 1'b0, 1'b1, 32'h42);
        n_total++;
        if (o_instruction !== 32'h0 || o_pc_if !== 32'h0 || o_pc !== 32'h40)
            $display("FAIL redirect_bubble: got ir=%h pcif=%h pc=%h want ir=0 pcif=0 pc=40",
                     o_instruction, o_pc_if, o_pc);
        else n_pass++;
        cyc(1'b0, '0, 32'h0, 1'b0, 1'b0, 32'h0);
        n_total++;
        if (o_instruction !== m_mem[16] || o_pc_if !== 32'h44 || o_pc !== 32'h44)
            $display("FAIL redirect_fetch: got ir=%h pcif=%h pc=%h want ir=%h pcif=44 pc=44",
                     o_instruction, o_pc_if, o_pc, m_mem[16]);
        else n_pass++;
    endtask

    task automatic test_redirect_stall();
        logic [31:0] held_ir;
        held_ir = m_ir;
        cyc(1'b0, '0, 32'h0, 1'b1, 1'b1, 32'h80);
        n_total++;
        if (o_pc !== 32'h44 || o_instruction !== held_ir)
            $display("FAIL redirect_stalled: got pc=%h ir=%h want pc=44 ir=%h",
                     o_pc, o_instruction, held_ir);
        else n_pass++;
        cyc(1'b0, '0, 32'h0, 1'b0, 1'b1, 32'h80);
        n_total++;
        if (o_pc !== 32'h80 || o_instruction !== 32'h0)
            $display("FAIL redirect_retry: got pc=%h ir=%h want pc=80 ir=0", o_pc, o_instruction);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        cyc(1'b0, '0, 32'h0, 1'b0, 1'b1, 32'h20);
        cyc(1'b0, '0, 32'h0, 1'b0, 1'b0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if ({o_instruction, o_pc_if, o_pc} !== 96'd0)
            $display("FAIL async_reset: got ir=%h pcif=%h pc=%h want all zero",
                     o_instruction, o_pc_if, o_pc);
        else n_pass++;
        rst = 1'b0;
        m_reset();
        cyc(1'b0, '0, 32'h0, 1'b0, 1'b0, 32'h0);
        n_total++;
        if (o_instruction !== 32'h20010005 || o_pc_if !== 32'h4)
            $display("FAIL mem_kept: got ir=%h pcif=%h want ir=20010005 pcif=4",
                     o_instruction, o_pc_if);
        else n_pass++;
    endtask

    task automatic test_halt();
        cyc(1'b1, AW'(3), HALTW, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, '0, 32'h0, (i == 5), (i == 5), 32'h100);
            n_total++;
            if ({o_instruction, o_pc_if, o_pc, o_halt} !== {m_ir, m_pcif, m_pc, m_halt})
                $display("FAIL halt_seq[%0d]: got ir=%h pcif=%h pc=%h halt=%b want ir=%h pcif=%h pc=%h halt=%b",
                         i, o_instruction, o_pc_if, o_pc, o_halt, m_ir, m_pcif, m_pc, m_halt);
            else n_pass++;
            if (i == 4) begin
                n_total++;
`ifdef HALT_DETECT_EN
                if (o_pc !== 32'h10 || o_halt !== 1'b1 || o_instruction !== 32'h0)
                    $display("FAIL halt_freeze: got pc=%h halt=%b ir=%h want pc=10 halt=1 ir=0",
                             o_pc, o_halt, o_instruction);
`else
                if (o_pc !== 32'h14 || o_halt !== 1'b0)
                    $display("FAIL halt_absent: got pc=%h halt=%b want pc=14 halt=0", o_pc, o_halt);
`endif
                else n_pass++;
            end
        end
        cyc(1'b1, AW'(3), 32'h00000020, 1'b0, 1'b0, 32'h0);
        n_total++;
        if (o_halt !== 1'b0 || o_pc !== 32'h0)
            $display("FAIL halt_clear: got halt=%b pc=%h want halt=0 pc=0", o_halt, o_pc);
        else n_pass++;
    endtask

    task automatic test_random();
        logic        le, st, jb;
        logic [31:0] tg, ld;
        for (int i = 0; i < 400; i++) begin
            le = ($urandom_range(0, 49) == 0);
            st = ($urandom_range(0, 3) == 0);
            jb = ($urandom_range(0, 6) == 0);
            tg = 32'($urandom_range(0, 1100));
            ld = ($urandom_range(0, 9) == 0) ? HALTW : $urandom;
            cyc(le, AW'($urandom_range(0, DEPTH - 1)), ld, st, jb, tg);
            n_total++;
            if ({o_instruction, o_pc_if, o_pc, o_halt} !== {m_ir, m_pcif, m_pc, m_halt})
                $display("FAIL random[%0d]: got ir=%h pcif=%h pc=%h halt=%b want ir=%h pcif=%h pc=%h halt=%b",
                         i, o_instruction, o_pc_if, o_pc, o_halt, m_ir, m_pcif, m_pc, m_halt);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_load_all();
        test_load_run();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_async_reset();
        test_halt();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
